// File: rtl/riscboy_ppu_mem_arbiter_pkg.sv
// Shared definitions for the PPU memory arbiter: transfer size encodings
// and arbitration mode selectors.
package riscboy_ppu_mem_arbiter_pkg;

    // Transfer size as presented by the PPU address generators.
    // SIZE_RSVD is never expected and is only flagged in simulation.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    // Arbitration policy selectors for the ARB_MODE parameter.
    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

endpackage

// File: rtl/riscboy_ppu_arb_rr.sv
// Rotating-priority one-hot arbiter. The search starts one position after
// the last requestor that was actually accepted, so a requestor that wins
// drops to lowest priority on the next arbitration. The pointer resets to
// N_REQ-1 so that requestor 0 has top priority after reset.
module riscboy_ppu_arb_rr #(
    parameter int N_REQ = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o
);

    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [W_IDX-1:0] last_q;
    logic [W_IDX-1:0] last_d;

    // Pick the first requestor at or after (last + 1), wrapping around.
    always_comb begin
        int  idx;
        logic found;
        grant_o = '0;
        last_d  = last_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                last_d       = W_IDX'(idx);
            end
        end
    end

    // The pointer only moves when the grant was really taken downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= W_IDX'(N_REQ - 1);
        end else if (advance_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/riscboy_ppu_mem_arbiter.sv
// PPU memory arbiter: funnels N_REQ address generators onto a single
// read-only memory port, then steers returned data back to whoever issued
// the matching address. Credit counts the issued-but-unreturned transfers,
// including the one sitting in the address pipestage, so all
// MAX_IN_FLIGHT slots of the return-mask FIFO can be used.
// Optional feature: define RISCBOY_PPU_ARB_PERF_EN to build the stall
// performance counter; otherwise perf_stall is tied to zero.
module riscboy_ppu_mem_arbiter
    import riscboy_ppu_mem_arbiter_pkg::*;
#(
    parameter int                N_REQ         = 10,
    parameter int                W_ADDR        = 18,
    parameter int                W_DATA        = 16,
    parameter logic [W_ADDR-1:0] ADDR_MASK     = {W_ADDR{1'b1}},
    parameter int                MAX_IN_FLIGHT = 5,
    parameter int                ARB_MODE      = 1,
    parameter int                PIPESTAGE_IN  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ppu_running,
    input  logic [N_REQ-1:0]          req_aph_vld,
    output logic [N_REQ-1:0]          req_aph_rdy,
    input  logic [2*N_REQ-1:0]        req_aph_size,
    input  logic [W_ADDR*N_REQ-1:0]   req_aph_addr,
    output logic [N_REQ-1:0]          req_dph_vld,
    output logic [W_DATA*N_REQ-1:0]   req_dph_data,
    output logic [W_ADDR-1:0]         mem_addr,
    output logic [1:0]                mem_size,
    output logic                      mem_addr_vld,
    input  logic                      mem_addr_rdy,
    input  logic [W_DATA-1:0]         mem_rdata,
    input  logic                      mem_rdata_vld,
    input  logic                      perf_clr,
    output logic [31:0]               perf_stall
);

    localparam int W_PTR = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;
    localparam int W_LVL = $clog2(MAX_IN_FLIGHT + 1);
    localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(MAX_IN_FLIGHT - 1);

    // Address pipestage
    logic [W_ADDR-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic              vld_q,  vld_d;

    // Return-mask FIFO
    logic [N_REQ-1:0]  fifo_q [MAX_IN_FLIGHT];
    logic [W_PTR-1:0]  wr_ptr_q, rd_ptr_q;
    logic [W_LVL-1:0]  level_q;
    logic              push, pop;

    // Arbitration
    logic [W_LVL:0]    in_flight;
    logic              issue_ok;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic              update;
    logic [W_ADDR-1:0] sel_addr;
    logic [1:0]        sel_size;

    // Read data, optionally registered
    logic [W_DATA-1:0] rdata_s;
    logic              rvld_s;

    assign in_flight = {1'b0, level_q} + (W_LVL + 1)'(vld_q);
    // rst_n is folded in so accept strobes are zero as soon as reset asserts.
    assign issue_ok  = rst_n && ppu_running && (in_flight < (W_LVL + 1)'(MAX_IN_FLIGHT));
    assign eligible  = req_aph_vld & {N_REQ{issue_ok}};
    assign update    = vld_q ? mem_addr_rdy : (|eligible);

    assign req_aph_rdy  = grant & {N_REQ{update}};
    assign mem_addr     = addr_q;
    assign mem_size     = size_q;
    assign mem_addr_vld = vld_q;

    generate
        if (ARB_MODE == ARB_MODE_RR) begin : g_rr
            riscboy_ppu_arb_rr #(
                .N_REQ (N_REQ)
            ) u_arb_rr (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_i     (eligible),
                .advance_i (|req_aph_rdy),
                .grant_o   (grant)
            );
        end else begin : g_fixed
            // Fixed priority: the lowest-numbered eligible requestor wins.
            always_comb begin
                logic found;
                grant = '0;
                found = 1'b0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (!found && eligible[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // One-hot mux of the winning requestor's address and size.
    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_aph_addr[i*W_ADDR +: W_ADDR];
                sel_size = sel_size | req_aph_size[2*i +: 2];
            end
        end
    end

    // Pipestage next state: reload only when empty or being accepted.
    always_comb begin
        addr_d = addr_q;
        size_d = size_q;
        mask_d = mask_q;
        vld_d  = vld_q;
        if (update) begin
            addr_d = sel_addr & ADDR_MASK;
            size_d = sel_size;
            mask_d = grant;
            vld_d  = |grant;
        end
    end

    // Pipestage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            size_q <= '0;
            mask_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            size_q <= size_d;
            mask_q <= mask_d;
            vld_q  <= vld_d;
        end
    end

    generate
        if (PIPESTAGE_IN != 0) begin : g_rpipe
            logic [W_DATA-1:0] rdata_q;
            logic              rvld_q;
            // Register returned data to break the path from the bus fabric.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rvld_q <= mem_rdata_vld;
                    if (mem_rdata_vld) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end
            assign rdata_s = rdata_q;
            assign rvld_s  = rvld_q;
        end else begin : g_rcomb
            assign rdata_s = mem_rdata;
            assign rvld_s  = mem_rdata_vld;
        end
    endgenerate

    assign push = vld_q && mem_addr_rdy;
    // Data arriving with nothing outstanding is discarded.
    assign pop  = rvld_s && (level_q != '0);

    assign req_dph_vld  = pop ? fifo_q[rd_ptr_q] : '0;
    assign req_dph_data = {N_REQ{rdata_s}};

    // FIFO storage; contents are only meaningful below the level count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mask_q;
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + W_PTR'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + W_PTR'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + W_LVL'(1);
                2'b01:   level_q <= level_q - W_LVL'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef RISCBOY_PPU_ARB_PERF_EN
    logic [31:0] perf_q;

    // Count cycles where someone wants the bus but nobody is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (perf_clr) begin
            perf_q <= '0;
        end else if ((|req_aph_vld) && !(|req_aph_rdy) && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall = perf_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_stall      = '0;
`endif

    // Read data with nothing outstanding means the memory side misbehaved.
    assert property (@(posedge clk) disable iff (!rst_n) !(rvld_s && (level_q == '0)));

    // The reserved size code is passed through but should never be issued.
    assert property (@(posedge clk) disable iff (!rst_n) !(vld_q && (size_q == SIZE_RSVD)));

endmodule
